// File: rtl/seq_detect_cfg.sv
// rtl/seq_detect_cfg.sv - run-time configurable serial bit-pattern detector
module seq_detect_cfg #(
    parameter int                 MAX_LEN         = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_1011,
    parameter int                 DEFAULT_LEN     = 4,
    parameter bit                 OVERLAP         = 1'b1,
    parameter int                 CNT_WIDTH       = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inp_bit,
    input  logic                         inp_valid,
    input  logic                         clear,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    output logic                         seq_seen,
    output logic [CNT_WIDTH-1:0]         match_count,
    output logic                         count_sat
);

    localparam int            LW        = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] pat_reg;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic [LW-1:0]      fill;
    logic [LW-1:0]      len_reg;
    logic [LW-1:0]      fill_inc;
    logic [LW-1:0]      len_load;
    logic               match;

    always_comb begin
        cand = {hist[MAX_LEN-2:0], inp_bit};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_reg));
        end
        // A match needs a full window of fresh bits and equality on the low len_reg bits only.
        match    = (({1'b0, fill} + 1'b1) >= {1'b0, len_reg}) &&
                   ((cand & mask) == (pat_reg & mask));
        fill_inc = (fill == MAX_LEN_L) ? fill : fill + 1'b1;
        len_load = ((cfg_len == '0) || (cfg_len > MAX_LEN_L)) ? MAX_LEN_L : cfg_len;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist        <= '0;
            fill        <= '0;
            pat_reg     <= DEFAULT_PATTERN;
            len_reg     <= LW'(DEFAULT_LEN);
            seq_seen    <= 1'b0;
            match_count <= '0;
        end else if (clear) begin
            hist        <= '0;
            fill        <= '0;
            pat_reg     <= cfg_pattern;
            len_reg     <= len_load;
            seq_seen    <= 1'b0;
            match_count <= '0;
        end else if (inp_valid) begin
            hist     <= cand;
            seq_seen <= match;
            // Non-overlap mode restarts the window so the next match uses only new bits.
            if (OVERLAP || !match) begin
                fill <= fill_inc;
            end else begin
                fill <= '0;
            end
            if (match && !(&match_count)) begin
                match_count <= match_count + 1'b1;
            end
        end else begin
            seq_seen <= 1'b0;
        end
    end

    assign count_sat = &match_count;

endmodule

// File: doc/seq_detect_cfg.md
Name: seq_detect_cfg

Overview:
- Parametrised, run-time-configurable serial bit-pattern detector; successor to the fixed 4-bit sequence detectors in the serial front-end.
- Detects a pattern of up to MAX_LEN bits in a qualified serial bit stream.
- Supports overlapping and non-overlapping match modes.
- Emits a one-cycle match pulse and keeps a saturating match count for status readout.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- DEFAULT_PATTERN, 8'b0000_1011, pattern loaded at reset; width MAX_LEN.
- DEFAULT_LEN, 4, pattern length loaded at reset (1..MAX_LEN).
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history restarts after each match.
- CNT_WIDTH, 8, width of the match counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- inp_bit  input  1  serial data bit.
- inp_valid  input  1  inp_bit is sampled only when 1.
- clear  input  1  synchronous clear and configuration load.
- cfg_pattern  input  MAX_LEN  pattern to load on clear; bit [len-1] is the first-received bit, bit 0 the last.
- cfg_len  input  $clog2(MAX_LEN+1)  pattern length to load on clear.
- seq_seen  output  1  registered one-cycle match pulse.
- match_count  output  CNT_WIDTH  saturating number of matches.
- count_sat  output  1  high while match_count is all-ones.

Behaviour:
- Reset (async, any time, including mid-stream) immediately drives:
  - seq_seen=0, match_count=0, count_sat=0;
  - history shift register=0, fill counter=0;
  - pat_reg=DEFAULT_PATTERN, len_reg=DEFAULT_LEN.
- Internal state:
  - hist[MAX_LEN-1:0] holds the most recent bits, newest at bit 0.
  - fill counts valid bits in the current history and saturates at MAX_LEN.
- Clear cycle (clear=1 on a rising edge):
  - hist=0, fill=0, match_count=0, seq_seen=0.
  - pat_reg=cfg_pattern.
  - len_reg=cfg_len, except cfg_len=0 or cfg_len>MAX_LEN loads MAX_LEN.
  - Clear has priority over inp_valid; the bit presented in that cycle is discarded.
- Accepted bit (inp_valid=1, clear=0):
  - cand = {hist[MAX_LEN-2:0], inp_bit}.
  - match = (fill+1 >= len_reg) AND (cand[len_reg-1:0] == pat_reg[len_reg-1:0]). Only the low len_reg bits are compared.
  - hist <= cand.
  - fill <= OVERLAP ? min(fill+1, MAX_LEN) : (match ? 0 : min(fill+1, MAX_LEN)).
  - seq_seen <= match.
  - On match, match_count increments if not all-ones; otherwise it holds (saturate, never wrap).
- Idle cycle (inp_valid=0, clear=0): hist, fill and match_count hold; seq_seen <= 0.
- Timing:
  - seq_seen rises in the cycle after the edge that sampled the final pattern bit, and is high for exactly one cycle per match.
  - Back-to-back matches (overlap mode, pattern length 1 or periodic patterns) give consecutive high cycles.
- count_sat = (match_count == all-ones). It is registered-derived: no combinational path from inputs to outputs.
- Invalid gaps in inp_valid do not break a partial match: bits are contiguous in the valid-qualified stream.
- cfg_pattern and cfg_len are ignored except in clear cycles.
- len_reg=1 is legal: every accepted bit equal to pat_reg[0] matches.

Test Plan:
- Default config (1011, OVERLAP=1): after reset, stream valid bits 1,0,1,1,0,1,1 -> seq_seen pulses after bit 4 and bit 7; match_count=2.
- OVERLAP=0, same stream -> single pulse after bit 4 only (bit 7 lacks a full fresh window); stream 1,0,1,1,1,0,1,1 -> pulses after bits 4 and 8.
- inp_valid gaps: 1,(gap x3),0,1,(gap),1 -> one pulse, exactly one cycle after the final valid bit; seq_seen low during all gap cycles.
- Runtime load: clear with cfg_pattern=3'b110 and cfg_len=3, inp_valid=1 and inp_bit=1 in the same cycle -> that bit is discarded and match_count=0; then 1,1,0,1,1,0 -> pulses after bits 3 and 6.
- Reset mid-operation: feed 1,0,1, assert reset asynchronously between edges -> outputs go to 0 immediately; after release, the next single 1 gives no match and 1,0,1,1 matches.
- CNT_WIDTH=2: produce 5 matches -> match_count reaches 3, holds at 3 with count_sat=1; clear -> match_count=0, count_sat=0.
